// File: rtl/fft_stream_pkg.sv
// Purpose: shared types, default sizes and helpers for the FFT result-stream sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fft_state_t framing FSM states, DEF_FFT_LEN/DEF_BIT_NUM defaults, clog2().
package fft_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    RESYNC = 2'd2
  } fft_state_t;

  localparam int DEF_FFT_LEN = 512;
  localparam int DEF_BIT_NUM = 24;

  // Ceiling log2, usable in parameter/port-width expressions.
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((32'd1 << k) < value) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Purpose: 2-entry skid buffer with registered ready, generic payload width.
// Latency: 1 cycle from push to pop_vld_o when empty; 1 beat/cycle sustained.
// Backpressure: push_rdy_o registered, high iff fewer than 2 entries held after this cycle.
// Ports: clk/rst (async active-high); push_i/push_dat_i/push_rdy_o upstream side;
//        pop_vld_o/pop_dat_o/pop_rdy_i downstream side.
module axis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  output logic         push_rdy_o,
  output logic         pop_vld_o,
  output logic [W-1:0] pop_dat_o,
  input  logic         pop_rdy_i
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         rdy_q;
  logic         push;
  logic         pop;

  // Push is gated by our own ready so a careless caller cannot overfill.
  assign push = push_i & rdy_q;
  assign pop  = pop_vld_o & pop_rdy_i;

  assign cnt_d = cnt_q + 2'(push) - 2'(pop);

  assign push_rdy_o = rdy_q;
  assign pop_vld_o  = (cnt_q != 2'd0);
  assign pop_dat_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) mem_q[k] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d < 2'd2);
    end
  end

endmodule

// File: rtl/fft_frame_sink.sv
// Purpose: AXI-Stream sink for FFT results: frame alignment check, I/Q split, drop-until-resync.
// Latency: 1 cycle from accepted beat to DATA_OUT_VALID when the skid buffer is empty.
// Backpressure: s_axis_tready registered from a 2-entry skid buffer driven by data_out_ready.
// Ports: SYS_CLK/SYS_RST; s_axis_* input stream; I/Q_DATA_OUT, DATA_OUT_VALID, data_out_ready,
//        out_first/out_last/out_index sideband; frame_cnt, err_*_cnt, err_pulse debug outputs.
module fft_frame_sink
  import fft_stream_pkg::*;
#(
  parameter  int BIT_NUM = DEF_BIT_NUM,
  parameter  int FFT_LEN = DEF_FFT_LEN,
  localparam int IDX_W   = clog2(FFT_LEN)
) (
  input  logic                      SYS_CLK,
  input  logic                      SYS_RST,
  input  logic [2*BIT_NUM-1:0]      s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic signed [BIT_NUM-1:0] I_DATA_OUT,
  output logic signed [BIT_NUM-1:0] Q_DATA_OUT,
  output logic                      DATA_OUT_VALID,
  input  logic                      data_out_ready,
  output logic                      out_first,
  output logic                      out_last,
  output logic [IDX_W-1:0]          out_index,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_early_cnt,
  output logic [15:0]               err_missing_cnt,
  output logic                      err_pulse
);

  localparam int                PW       = 2 + IDX_W + 2*BIT_NUM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  fft_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      frame_cnt_q, err_early_cnt_q, err_missing_cnt_q;
  logic             err_pulse_q;

  logic             accept;
  logic             fwd;
  logic             tag_first, tag_last;
  logic             ev_good, ev_early, ev_missing;
  logic [PW-1:0]    push_dat;
  logic [PW-1:0]    pop_dat;

  assign accept = s_axis_tvalid & s_axis_tready;
  // Beats seen while resynchronising are consumed but never written to the buffer.
  assign fwd    = accept & (state_q != RESYNC);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_first  = 1'b0;
    tag_last   = 1'b0;
    ev_good    = 1'b0;
    ev_early   = 1'b0;
    ev_missing = 1'b0;
    case (state_q)
      // IDLE and RECV share one path: idx_q is always 0 in IDLE, so an IDLE
      // beat with tlast lands in the early-end branch (or good end if FFT_LEN==1).
      IDLE, RECV: begin
        if (accept) begin
          tag_first = (state_q == IDLE);
          if (s_axis_tlast) begin
            tag_last = 1'b1;
            ev_good  = (idx_q == LAST_IDX);
            ev_early = (idx_q != LAST_IDX);
            state_d  = IDLE;
            idx_d    = '0;
          end else if (idx_q == LAST_IDX) begin
            tag_last   = 1'b1;
            ev_missing = 1'b1;
            state_d    = RESYNC;
            idx_d      = '0;
          end else begin
            state_d = RECV;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      RESYNC: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      frame_cnt_q       <= 16'd0;
      err_early_cnt_q   <= 16'd0;
      err_missing_cnt_q <= 16'd0;
      err_pulse_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_pulse_q <= ev_early | ev_missing;
      if (ev_good) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (ev_early && err_early_cnt_q != 16'hFFFF)
        err_early_cnt_q <= err_early_cnt_q + 16'd1;
      if (ev_missing && err_missing_cnt_q != 16'hFFFF)
        err_missing_cnt_q <= err_missing_cnt_q + 16'd1;
    end
  end

  // tdata is already {Q, I}, so the payload is a plain concatenation.
  assign push_dat = {tag_first, tag_last, idx_q, s_axis_tdata};

  axis_skid2 #(
    .W (PW)
  ) u_skid (
    .clk        (SYS_CLK),
    .rst        (SYS_RST),
    .push_i     (fwd),
    .push_dat_i (push_dat),
    .push_rdy_o (s_axis_tready),
    .pop_vld_o  (DATA_OUT_VALID),
    .pop_dat_o  (pop_dat),
    .pop_rdy_i  (data_out_ready)
  );

  assign {out_first, out_last, out_index, Q_DATA_OUT, I_DATA_OUT} = pop_dat;

  assign frame_cnt       = frame_cnt_q;
  assign err_early_cnt   = err_early_cnt_q;
  assign err_missing_cnt = err_missing_cnt_q;
  assign err_pulse       = err_pulse_q;

endmodule

// File: doc/fft_frame_sink.md
# fft_frame_sink

Receive-side AXI-Stream endpoint for the FFT/IFFT result stream (`m_axis_data_*` of the FFT core), the counterpart to the FIFO-driven input framer that feeds `s_axis_data_*`.
- Accepts 48-bit packed complex samples and checks frame alignment against `FFT_LEN` and `tlast`.
- Splits each sample into signed I/Q and forwards it through a 2-entry skid buffer with downstream backpressure.
- Drops misaligned data until resync and keeps frame and error counters for debug (ILA) and bench checking.

## Interface
Parameters:
- `BIT_NUM`, 24: width of each I/Q component; `tdata` width is `2*BIT_NUM`.
- `FFT_LEN`, 512: samples per frame; power of two, 8..65536.

Ports:
- `SYS_CLK`  in  1  sole clock; one clock, all logic on its rising edge.
- `SYS_RST`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  2*BIT_NUM  `[BIT_NUM-1:0]` = real (I), `[2*BIT_NUM-1:BIT_NUM]` = imag (Q).
- `s_axis_tvalid`  in  1  upstream sample valid.
- `s_axis_tlast`  in  1  upstream end-of-frame marker.
- `s_axis_tready`  out  1  block can accept a beat.
- `I_DATA_OUT`  out  BIT_NUM  signed real part.
- `Q_DATA_OUT`  out  BIT_NUM  signed imag part.
- `DATA_OUT_VALID`  out  1  output beat valid.
- `data_out_ready`  in  1  downstream accepts the beat.
- `out_first`  out  1  beat is sample index 0 of a frame.
- `out_last`  out  1  beat is the final sample of a frame, good or early.
- `out_index`  out  log2(FFT_LEN)  sample index within the frame.
- `frame_cnt`  out  16  good frames received; wraps.
- `err_early_cnt`  out  16  early-`tlast` events; saturates at 0xFFFF.
- `err_missing_cnt`  out  16  missing-`tlast` events; saturates at 0xFFFF.
- `err_pulse`  out  1  one-cycle pulse on any framing error.

## Operation
- Beat accepted when `s_axis_tvalid & s_axis_tready`.
- Index counter `idx`, 0..FFT_LEN-1, increments on each accepted forwarded beat.
- FSM states `IDLE`, `RECV`, `RESYNC`. Reset state is `IDLE`.
- `IDLE`: the next accepted beat is `idx=0`, tagged `out_first=1`, and the FSM moves to `RECV`.
  - If that beat also has `tlast` and `FFT_LEN>1`, it is an early `tlast`: `out_last=1`, error pulse, stay in `IDLE`.
- `RECV`, beat accepted:
  - `idx==FFT_LEN-1` and `tlast=1`: good end. `out_last=1`, `frame_cnt+1`, go to `IDLE`, `idx` cleared.
  - `idx<FFT_LEN-1` and `tlast=1`: early end. Beat is forwarded with `out_last=1`, `err_early_cnt+1`, `err_pulse`, go to `IDLE`.
  - `idx==FFT_LEN-1` and `tlast=0`: missing `tlast`. Beat is forwarded with `out_last=1`, `err_missing_cnt+1`, `err_pulse`, go to `RESYNC`.
- `RESYNC`: accepted beats are dropped (not written to the buffer). A beat with `tlast=1` is also dropped, then the FSM goes to `IDLE`. `s_axis_tready` stays asserted.
- I/Q split is a pure bit-slice with no rounding or sign change. `out_index`, `out_first` and `out_last` travel with the data through the buffer.

## Timing
- Reset values: `s_axis_tready=0`, `DATA_OUT_VALID=0`, I/Q/index/flags 0, all counters 0, `err_pulse=0`, FSM `IDLE`, buffer empty.
  - `s_axis_tready` goes to 1 on the first clock edge after `SYS_RST` deasserts.
- Skid buffer holds 2 entries. `s_axis_tready` is registered: 1 iff fewer than 2 entries occupied after this cycle's push/pop.
- Latency: an accepted beat appears on the outputs one cycle later when the buffer is empty.
- While `DATA_OUT_VALID=1 && data_out_ready=0`, output data and flags hold stable.
- Simultaneous push and pop with the buffer full is not possible (`tready=0`). With 1 entry occupied, push and pop in the same cycle keeps the occupancy at 1.
- Full throughput is 1 beat/cycle while `data_out_ready=1`.
- Counters and `err_pulse` update on the cycle after the triggering beat is accepted, not when it is output.
- `SYS_RST` mid-frame: immediate clear, and buffered beats are discarded.

## Structure
- Shared package `fft_stream_pkg`:
  - `fft_state_t` enum (`IDLE`/`RECV`/`RESYNC`).
  - Default `FFT_LEN`/`BIT_NUM` constants.
  - Function `clog2` for index width.
- One sub-module, `axis_skid2`: parameterised-width 2-entry skid buffer with registered `tready`, holding the payload `{first,last,index,Q,I}`.
- Top level holds the FSM, index counter and counters.

## Test plan
- FFT_LEN=8, 3 back-to-back frames, tlast on beat 7, ready=1:
  - Outputs idx 0..7 repeat.
  - `out_first` on idx 0, `out_last` on idx 7.
  - `frame_cnt=3`, error counters 0.
  - I/Q bit-exact (e.g. tdata=0xFFFFFF_000001 → I=+1, Q=-1).
- tlast on beat 4 of a frame:
  - 5 beats output, last with `out_last=1`.
  - `err_early_cnt=1`, `err_pulse` for 1 cycle.
  - Next beat is idx 0.
- No tlast at beat 7, then 5 beats with tlast on the 5th:
  - Beats 0..7 forwarded, `err_missing_cnt=1`.
  - The 5 beats are dropped.
  - Following beat is idx 0 with `out_first`.
- Random `data_out_ready` (30 % low) over 100 frames:
  - No loss or duplication; output order matches input.
  - `s_axis_tready` never low while the buffer has a free entry.
- `SYS_RST` asserted at idx 3 with 2 entries buffered:
  - All outputs and counters 0 during reset.
  - `tready=1` one cycle after release.
  - Next beat is idx 0.
